// File: rtl/time_alarm_core.sv
// Seconds/minutes/hours/day timekeeper with user-settable time and alarm registers.
// The alarm comparator downstream consumes the registered time and alarm fields directly.
module time_alarm_core #(
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HRS_MOD = 24,
  parameter int unsigned DAY_MOD = 7
) (
  input  logic       Pulse,
  input  logic       Reset,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] tday,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic [6:0] aday
);

  typedef enum logic [1:0] {ModeRun, ModeTset, ModeAset} mode_e;

  localparam logic [6:0] SecMax = 7'(SEC_MOD - 1);
  localparam logic [6:0] MinMax = 7'(MIN_MOD - 1);
  localparam logic [6:0] HrsMax = 7'(HRS_MOD - 1);

  // Wraps at MOD-1 and also recovers any out-of-range value to 0.
  function automatic logic [6:0] inc_mod(input logic [6:0] v, input int unsigned m);
    logic [6:0] lim;
    lim = 7'(m - 1);
    return (v >= lim) ? 7'd0 : v + 7'd1;
  endfunction

  logic [6:0] tsec_q, tmin_q, thrs_q, tday_q, amin_q, ahrs_q, aday_q;
  logic [6:0] tsec_d, tmin_d, thrs_d, tday_d, amin_d, ahrs_d, aday_d;
  logic       min_carry, hrs_carry, day_carry;
  mode_e      mode;

  always_comb begin
    if (Timeset)       mode = ModeTset;
    else if (Alarmset) mode = ModeAset;
    else               mode = ModeRun;
  end

  assign min_carry = (tsec_q == SecMax);
  assign hrs_carry = min_carry && (tmin_q == MinMax);
  assign day_carry = hrs_carry && (thrs_q == HrsMax);

  always_comb begin
    tsec_d = tsec_q;
    tmin_d = tmin_q;
    thrs_d = thrs_q;
    tday_d = tday_q;
    amin_d = amin_q;
    ahrs_d = ahrs_q;
    aday_d = aday_q;
    unique case (mode)
      ModeTset: begin
        if (Minadv) tmin_d = inc_mod(tmin_q, MIN_MOD);
        if (Hrsadv) thrs_d = inc_mod(thrs_q, HRS_MOD);
        if (Dayadv) tday_d = inc_mod(tday_q, DAY_MOD);
      end
      ModeAset, ModeRun: begin
        // The clock keeps running while the alarm is being set.
        tsec_d = inc_mod(tsec_q, SEC_MOD);
        if (min_carry) tmin_d = inc_mod(tmin_q, MIN_MOD);
        if (hrs_carry) thrs_d = inc_mod(thrs_q, HRS_MOD);
        if (day_carry) tday_d = inc_mod(tday_q, DAY_MOD);
        if (mode == ModeAset) begin
          if (Minadv) amin_d = inc_mod(amin_q, MIN_MOD);
          if (Hrsadv) ahrs_d = inc_mod(ahrs_q, HRS_MOD);
          if (Dayadv) aday_d = inc_mod(aday_q, DAY_MOD);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Pulse or posedge Reset) begin
    if (Reset) begin
      tsec_q <= '0;
      tmin_q <= '0;
      thrs_q <= '0;
      tday_q <= '0;
      amin_q <= '0;
      ahrs_q <= '0;
      aday_q <= '0;
    end else begin
      tsec_q <= tsec_d;
      tmin_q <= tmin_d;
      thrs_q <= thrs_d;
      tday_q <= tday_d;
      amin_q <= amin_d;
      ahrs_q <= ahrs_d;
      aday_q <= aday_d;
    end
  end

  assign tsec = tsec_q;
  assign tmin = tmin_q;
  assign thrs = thrs_q;
  assign tday = tday_q;
  assign amin = amin_q;
  assign ahrs = ahrs_q;
  assign aday = aday_q;

endmodule

// File: doc/time_alarm_core.md
Name: time_alarm_core

Overview:
- Timekeeping and alarm-setting stage that sits directly upstream of the alarm comparator and drives its tmin/thrs/tday and amin/ahrs/aday inputs.
- Each Pulse edge is one second of real time.
- In run mode the block keeps a seconds/minutes/hours/day-of-week count with carries.
- In set modes the user advance buttons step either the time registers or the alarm registers.

Parameters:
- SEC_MOD, 60, seconds modulus (tsec counts 0..SEC_MOD-1)
- MIN_MOD, 60, minutes modulus
- HRS_MOD, 24, hours modulus
- DAY_MOD, 7, day-of-week modulus (0..6)

Ports:
- Pulse  input  1  clock; one rising edge per second
- Reset  input  1  asynchronous, active-high reset
- Timeset  input  1  time-set mode select
- Alarmset  input  1  alarm-set mode select
- Minadv  input  1  advance minutes (set modes only)
- Hrsadv  input  1  advance hours (set modes only)
- Dayadv  input  1  advance day (set modes only)
- tsec  output  7  current seconds
- tmin  output  7  current minutes
- thrs  output  7  current hours
- tday  output  7  current day of week
- amin  output  7  alarm minutes
- ahrs  output  7  alarm hours
- aday  output  7  alarm day of week

Behaviour:
- Clock domain: all state on rising Pulse. Reset is asynchronous, active-high, and forces all seven outputs to 0 immediately. Outputs are registered; no combinational path from inputs to outputs.
- Mode decode, per cycle from sampled inputs:
  - TSET if Timeset=1 (Timeset has priority over Alarmset).
  - ASET if Timeset=0 and Alarmset=1.
  - RUN otherwise.
- RUN:
  - tsec <= (tsec+1) mod SEC_MOD.
  - tmin increments only when tsec==SEC_MOD-1.
  - thrs increments only when tsec==SEC_MOD-1 and tmin==MIN_MOD-1.
  - tday increments only when all three lower fields are at max. Example: 23:59:59 day 6 -> 00:00:00 day 0 in one edge.
  - Advance inputs are ignored.
  - Alarm registers hold.
- TSET:
  - tsec holds (clock frozen while setting).
  - Minadv=1: tmin <= (tmin+1) mod MIN_MOD, with no carry into thrs.
  - Hrsadv=1: thrs <= (thrs+1) mod HRS_MOD, with no carry into tday.
  - Dayadv=1: tday <= (tday+1) mod DAY_MOD.
  - Multiple advance inputs asserted together each act on their own field in the same edge.
  - Alarm registers hold.
- ASET:
  - Same stepping rules applied to amin/ahrs/aday; no carries.
  - The time registers continue to run exactly as in RUN. Setting the alarm never stops the clock.
- Width/range:
  - Fields are 7-bit unsigned; upper bits stay 0 in all legal operation.
  - Increment/compare use a full 7-bit width with explicit modulus compare (value==MOD-1 -> 0). No reliance on truncation.
  - If a field somehow holds a value >= its MOD, the next increment loads 0.
- Mode changes take effect on the edge where the new level is sampled; there is no pipeline latency and no edge detection. A held advance button steps once per Pulse.
- Reset asserted mid-count or mid-set clears everything. After deassertion the block resumes in the mode given by the inputs at the next edge.

Test Plan:
- Reset pulse with arbitrary prior state -> all outputs 0 asynchronously, before any Pulse edge.
- RUN from 00:00:00 day 0, 60 Pulses -> tsec=0, tmin=1, thrs=0, tday=0. Preload 23:59:59 day 6 via TSET steps, then 1 RUN Pulse -> 00:00:00 day 0.
- TSET with Minadv held 61 Pulses from tmin=0 -> tmin=1, thrs unchanged, tsec unchanged throughout.
- ASET with Hrsadv and Dayadv held 25 Pulses -> ahrs=1, aday=4 (25 mod 7). Time fields meanwhile advance 25 seconds.
- Timeset=1 and Alarmset=1 together, Minadv=1 for 3 Pulses -> tmin+3, amin unchanged.
- Reset asserted mid-ASET with amin=30 -> amin=0 immediately. After release with Alarmset=0, the next Pulse gives tsec=1.
